// File: rtl/bin2bcd_converter.sv
// bin2bcd_converter: sequential double-dabble binary to 8-digit packed BCD
// with leading-zero blanking and overflow saturation at 99_999_999.
module bin2bcd_converter #(
   parameter int IN_W = 27
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [IN_W-1:0] BIN,
   input  logic            START,
   input  logic            BLANK_LZ,
   output logic            BUSY,
   output logic            DONE,
   output logic            OVF,
   output logic [33:0]     NUM
);
   localparam int CNT_W = $clog2(IN_W + 1);
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;
   state_t r_state, w_next;
   logic [IN_W-1:0]  r_bin;
   logic [31:0]      r_bcd, w_adj, w_res;
   logic [CNT_W-1:0] r_cnt;
   logic             r_blank, r_ovf_in, r_done, r_ovf, w_lead, w_start, w_last, w_big;
   logic [33:0]      r_num;
   logic [IN_W+31:0] w_bin_ext;
   assign w_start   = (r_state == S_IDLE) && START;
   assign w_last    = r_cnt == CNT_W'(IN_W - 1);
   assign w_bin_ext = {32'd0, BIN};
   assign w_big     = w_bin_ext > (IN_W + 32)'(99_999_999);
   assign BUSY      = r_state != S_IDLE;
   assign DONE      = r_done;
   assign OVF       = r_ovf;
   assign NUM       = r_num;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = (r_state == S_IDLE)  ? (START ? S_SHIFT : S_IDLE) :
               (r_state == S_SHIFT) ? (w_last ? S_FINISH : S_SHIFT) : S_IDLE;
   end
   for (genvar g = 0; g < 8; g++) begin : g_adj
      assign w_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3 : r_bcd[4*g +: 4];
   end
   // Blank from the top digit down while digits stay zero; digit 0 always shown.
   always_comb begin
      w_res  = r_bcd;
      w_lead = r_blank;
      for (int i = 7; i >= 1; i--) begin
         w_lead = w_lead && (r_bcd[4*i +: 4] == 4'd0);
         if (w_lead) w_res[4*i +: 4] = 4'hF;
      end
      if (r_ovf_in) w_res = 32'h9999_9999;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_bin    <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_blank  <= 1'b0;
         r_ovf_in <= 1'b0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_num    <= '0;
      end else begin
         r_done <= r_state == S_FINISH;
         if (w_start) begin
            r_bin    <= BIN;
            r_blank  <= BLANK_LZ;
            r_ovf_in <= w_big;
            r_bcd    <= '0;
            r_cnt    <= '0;
         end else if (r_state == S_SHIFT) begin
            r_bcd <= {w_adj[30:0], r_bin[IN_W-1]};
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt + 1'b1;
         end else if (r_state == S_FINISH) begin
            r_num <= {2'b00, w_res};
            r_ovf <= r_ovf_in;
         end
      end
   end
endmodule

// File: doc/bin2bcd_converter.md
BIN2BCD_CONVERTER -- requirements
Module: bin2bcd_converter

Interface
REQ-001 The block SHALL have one parameter: IN_W, default 27, width of the binary input (27 bits covers 0..99_999_999).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, named CLK and RST as elsewhere in the codebase.
REQ-003 CLK  input  1  system clock, 1 MHz.
REQ-004 RST  input  1  asynchronous active-high reset.
REQ-005 BIN  input  IN_W  unsigned binary value to convert; sampled only when a START is accepted.
REQ-006 START  input  1  conversion request; accepted only in IDLE.
REQ-007 BLANK_LZ  input  1  leading-zero blanking enable; sampled with BIN.
REQ-008 BUSY  output  1  high whenever state is not IDLE.
REQ-009 DONE  output  1  one-cycle pulse marking the cycle in which NUM updates.
REQ-010 OVF  output  1  overflow flag for the last completed conversion.
REQ-011 NUM  output  34  packed BCD result for the 7-segment scanner.
  - Digit0 = NUM[3:0] … Digit7 = NUM[31:28].
  - NUM[33:32] SHALL always be 0.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and FINISH.
  - IDLE -> SHIFT on START=1.
  - SHIFT -> FINISH after IN_W iterations.
  - FINISH -> IDLE unconditionally.
REQ-013 On the edge that accepts START, the block SHALL latch BIN and BLANK_LZ, clear a 32-bit BCD scratch register, and clear the iteration counter.
REQ-014 Each SHIFT cycle SHALL perform one double-dabble iteration.
  - Add 3 to every scratch digit >= 5.
  - Then shift {scratch, shift-reg} left by one, taking in the MSB of the latched binary.
REQ-015 The iteration counter SHALL run 0..IN_W-1; on count IN_W-1 the state SHALL go to FINISH.
REQ-016 In FINISH, the block SHALL register the final NUM, assert DONE for exactly that one cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed:
  - START sampled at edge k -> NUM valid and DONE=1 after edge k+IN_W+1 (28 cycles for IN_W=27).
  - Latency SHALL be independent of the BIN value.
REQ-018 If the latched BIN > 99_999_999, NUM[31:0] SHALL be 32'h99999999 and OVF=1; otherwise OVF=0.
  - OVF SHALL update together with NUM.
REQ-019 With BLANK_LZ latched = 1, leading zero digits SHALL be replaced by 4'hF, scanning from Digit7 downward until the first nonzero digit.
  - Digit0 SHALL never be blanked.
  - Overflow results SHALL never be blanked.
REQ-020 NUM and OVF SHALL hold their previous values from START acceptance until the FINISH update; no intermediate values SHALL appear on NUM.
REQ-021 START while BUSY=1 SHALL be ignored, with no queueing and no effect on the running conversion.
REQ-022 START asserted in the same cycle DONE=1 SHALL be accepted, because that cycle is IDLE.
REQ-023 START held high continuously SHALL produce back-to-back conversions, one every IN_W+2 cycles.
REQ-024 BIN and BLANK_LZ changes during BUSY SHALL have no effect.

Reset
REQ-025 While RST=1, regardless of CLK:
  - State SHALL be IDLE.
  - NUM SHALL be 34'h0, displaying 00000000.
  - BUSY=0, DONE=0, OVF=0.
  - Scratch and counter SHALL be cleared.
REQ-026 RST asserted mid-conversion SHALL abort the conversion.
  - No DONE pulse SHALL occur.
  - NUM SHALL read 0 after release.
REQ-027 After RST falls, the first START SHALL be accepted on the next rising CLK.

Verification
REQ-028 BIN=0, BLANK_LZ=0, START pulse -> after 28 cycles DONE=1, NUM=34'h0, OVF=0; with BLANK_LZ=1, NUM[31:0]=32'hFFFFFFF0.
REQ-029 BIN=12_345_678, BLANK_LZ=0 -> NUM[31:0]=32'h12345678, NUM[33:32]=0, OVF=0, DONE exactly one cycle.
REQ-030 BIN=305, BLANK_LZ=1 -> NUM[31:0]=32'hFFFFF305; then BIN=99_999_999 -> NUM[31:0]=32'h99999999, OVF=0.
REQ-031 BIN=100_000_000 and BIN=2^27-1 -> NUM[31:0]=32'h99999999, OVF=1, no blanking even with BLANK_LZ=1.
REQ-032 START with BIN=42; second START with BIN=7 at cycle 10; RST pulse during a third conversion:
  - First result NUM[31:0]=32'h00000042, only one DONE pulse.
  - After the reset pulse, NUM=0, BUSY=0, no DONE.
REQ-033 START held high with alternating BIN=1/BIN=2 -> DONE every 29 cycles, results alternating 32'h1/32'h2 per latched value.
